msg_frame_packer: RTL
=====================

# msg_frame_packer

Upstream stage of the encryptor. Accepts plaintext one byte per cycle over a valid/ready stream and assembles it into a parallel MSG_LEN-byte frame, the array form the encryptor's `text_in` consumes. Short messages, closed by `in_last`, are padded to MSG_LEN with a fixed pad byte. The completed frame is held stable behind an output valid/ready handshake until the downstream side takes it.

## Interface
- `MSG_LEN`, default 1: frame length in bytes; legal range 1..255.
- `PAD_BYTE`, default 8'h00: fill value for unused positions of a short frame.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  8: plaintext byte.
- `in_valid`  in  1: `in_data` and `in_last` are valid this cycle.
- `in_last`  in  1: this byte ends the message.
- `in_ready`  out  1: packer can accept a byte this cycle.
- `text_out`  out  [7:0] x [0:MSG_LEN-1]: assembled frame; index 0 is the first byte received; connects directly to encryptor `text_in`.
- `out_len`  out  8: count of real (non-pad) bytes in the frame, 1..MSG_LEN.
- `out_valid`  out  1: frame on `text_out` is complete and stable.
- `out_ready`  in  1: downstream consumes the frame this cycle.
- `frame_cnt`  out  16: number of frames handed off since reset.

## Operation
- Two states: FILL and HOLD.
- FILL:
  - `in_ready` = 1 and `out_valid` = 0.
  - A byte is accepted when `in_valid && in_ready`; it is written to `buf[idx]`.
  - If `idx == MSG_LEN-1` or `in_last` = 1, go to HOLD:
    - `out_len` <= idx+1.
    - Every position idx+1..MSG_LEN-1 is written with PAD_BYTE in the same edge.
    - `idx` <= 0.
  - Otherwise `idx` <= idx+1.
- HOLD:
  - `in_ready` = 0 and `out_valid` = 1.
  - `text_out` and `out_len` do not change.
  - When `out_ready` = 1, go to FILL and increment `frame_cnt` (wraps 16'hFFFF -> 0).
  - `text_out` keeps its last value after handoff until overwritten.
- `in_last` is ignored unless `in_valid` = 1.
- With MSG_LEN = 1, every accepted byte closes a frame, with or without `in_last`.
- `text_out` is driven directly from `buf`. There is no combinational path from `in_data` to `text_out`.
- `in_ready` depends only on state and `rst`. It has no combinational dependence on `out_ready`, so an input can never be accepted in the same cycle as a handoff.
- Reset values:
  - state = FILL, `idx` = 0.
  - All `buf` entries = PAD_BYTE.
  - `out_len` = 0, `out_valid` = 0, `frame_cnt` = 0.
  - `in_ready` = 0 while `rst` is high.
- Reset asserted mid-frame or in HOLD discards the partial or held frame; `frame_cnt` does not increment.

## Timing
- A byte accepted at edge N is visible in `buf` after edge N.
- The closing byte accepted at edge N gives `out_valid` = 1 in the cycle after N, with the full frame and padding already in place.
- Handoff at edge M (`out_valid && out_ready`) gives `in_ready` = 1 in the cycle after M.
- Minimum frame period is MSG_LEN+1 cycles.
- Gaps in `in_valid` stall assembly with no state change.
- Holding `out_ready` low holds HOLD indefinitely. No bytes are lost, because `in_ready` = 0 throughout.
- `in_valid` is permitted while `in_ready` = 0; the byte is not consumed and the source must hold it.

## Test plan
- MSG_LEN=1: reset, send "H" (8'h48) with `out_ready`=1 -> `out_valid` one cycle after accept, `text_out[0]`=8'h48, `out_len`=1, `frame_cnt`=1 after the next edge.
- MSG_LEN=4, PAD_BYTE=8'h00: send "HI" with `in_last` on "I" -> frame {48,49,00,00}, `out_len`=2.
- MSG_LEN=4: send "ABCDE" back-to-back with `out_ready` low for 5 cycles -> first frame {41,42,43,44} held stable; `in_ready`=0 with "E" pending; after `out_ready`, "E" accepted, then frame 2 starts.
- MSG_LEN=3: assert `rst` after 2 bytes, then send "XYZ" -> frame {58,59,5A}, `frame_cnt`=1, no trace of the pre-reset bytes.
- Preload `frame_cnt` to 16'hFFFF by running 65535 one-byte frames with MSG_LEN=1 -> the next handoff gives `frame_cnt`=0.
- Packer feeding encryptor feeding decryptor, MSG_LEN=5, message "HELLO" -> decryptor output equals {48,45,4C,4C,4F}.

Source files
------------

// File: rtl/msg_frame_packer.sv
// Byte-stream to parallel-frame packer: collects up to MSG_LEN bytes, pads short
// messages with PAD_BYTE and holds the finished frame behind a valid/ready handshake.
module msg_frame_packer #(
    parameter int         MSG_LEN  = 1,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] text_out [0:MSG_LEN-1],
    output logic [7:0] out_len,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [15:0] frame_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] idx;
    logic [7:0] frame_buf [0:MSG_LEN-1];
    logic       accept;
    logic       close;
    logic       handoff;

    // NOTE: every signal gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        close      = 1'b0;
        handoff    = 1'b0;
        case (state)
            FILL: begin
                in_ready = !rst;
                accept   = in_valid && !rst;
                close    = accept && (in_last || (idx == LAST_IDX));
                if (close) state_next = HOLD;
            end
            HOLD: begin
                out_valid = !rst;
                handoff   = out_ready && !rst;
                if (handoff) state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 8'd0;
            out_len   <= 8'd0;
            frame_cnt <= 16'd0;
            // NOTE: the frame buffer is reset explicitly because a freshly
            // reset packer must present an all-pad frame, not stale contents.
            for (int i = 0; i < MSG_LEN; i++) frame_buf[i] <= PAD_BYTE;
        end else begin
            frame_cnt <= frame_cnt + {15'd0, handoff};
            if (accept) begin
                idx <= close ? 8'd0 : idx + 8'd1;
                if (close) out_len <= idx + 8'd1;
                // Closing byte and its trailing padding land on the same edge.
                for (int i = 0; i < MSG_LEN; i++) begin
                    if (8'(i) == idx)
                        frame_buf[i] <= in_data;
                    else if (close && (8'(i) > idx))
                        frame_buf[i] <= PAD_BYTE;
                end
            end
        end
    end

    assign text_out = frame_buf;

endmodule
